// File: rtl/counter_seq_pkg.sv
// ---------------------------------------------------------------
// counter_seq_pkg : shared types for the step sequencer and counter
// rev 1.0
// ---------------------------------------------------------------
`default_nettype none
package counter_seq_pkg;
  localparam int unsigned DEF_OPW   = 3;
  localparam int unsigned DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  typedef struct packed {
    logic [DEF_OPW-1:0]   opcode;
    logic [DEF_WIDTH-1:0] data;
  } step_t;
endpackage
`default_nettype wire

// File: rtl/counter_sequencer_if.sv
// ---------------------------------------------------------------
// counter_sequencer_if : step bus from the sequencer to the counter
// rev 1.0
// ---------------------------------------------------------------
`default_nettype none
interface counter_sequencer_if #(
  parameter int OPW   = 3,
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  localparam int SW = $clog2(DEPTH);

  logic [OPW-1:0]   opcode_out;
  logic [WIDTH-1:0] data_out;
  logic             cnt_en;
  logic [SW-1:0]    step;
  logic [SW:0]      prog_len;
  logic             running;

  modport master (output opcode_out, data_out, cnt_en, step, prog_len, running);
  modport slave  (input  opcode_out, data_out, cnt_en, step, prog_len, running);
endinterface
`default_nettype wire

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------
// button_conditioner : 2-flop sync, debounce, press (1->0) pulse
// rev 1.0
// ---------------------------------------------------------------
`default_nettype none
module button_conditioner #(
  parameter int DEB_CYCLES = 10000
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_btn_n,
  output logic      o_press
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [1:0]    r_sync;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_press;

  // r_cnt counts consecutive samples that disagree with the accepted level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b11;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn_n};
      r_press <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
        r_press <= ~r_sync[1];
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_press = r_press;
endmodule
`default_nettype wire

// File: rtl/counter_sequencer.sv
// ---------------------------------------------------------------
// counter_sequencer : programmable step sequencer for the counter
// rev 1.0
// ---------------------------------------------------------------
`default_nettype none
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int OPW        = int'(DEF_OPW),
  parameter int WIDTH      = int'(DEF_WIDTH),
  parameter int TICK_DIV   = 50000000,
  parameter int DEB_CYCLES = 10000
) (
  input  wire logic             clk,
  input  wire logic             reset_async,
  input  wire logic             load_btn,
  input  wire logic             run_btn,
  input  wire logic             enable,
  input  wire logic [OPW-1:0]   sw_opcode,
  input  wire logic [WIDTH-1:0] sw_data,
  counter_sequencer_if.master   bus
);
  localparam int SW = $clog2(DEPTH);
  localparam int PW = $clog2(TICK_DIV);

  typedef struct packed {
    logic [OPW-1:0]   opcode;
    logic [WIDTH-1:0] data;
  } entry_t;

  logic w_load, w_run, w_tick;
  state_t r_state, w_state_nxt;
  entry_t           r_prog [DEPTH];
  logic [SW:0]      r_len;
  logic [SW-1:0]    r_rd;
  logic [PW-1:0]    r_presc;
  logic [OPW-1:0]   r_op;
  logic [WIDTH-1:0] r_data;
  logic [SW-1:0]    r_step;
  logic             r_cnt_en;
  logic             r_running;

  button_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_load_btn (
    .clk(clk), .rst_n(reset_async), .i_btn_n(load_btn), .o_press(w_load));
  button_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_run_btn (
    .clk(clk), .rst_n(reset_async), .i_btn_n(run_btn), .o_press(w_run));

  assign w_tick = (r_state == ST_RUN) && enable && (r_presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge reset_async) begin
    if (!reset_async) r_state <= ST_IDLE;
    else              r_state <= w_state_nxt;
  end

  // load outranks run in IDLE and PAUSE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (!w_load && w_run && r_len != '0) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_run) w_state_nxt = ST_PAUSE;
      ST_PAUSE: begin
        if (w_load)     w_state_nxt = ST_IDLE;
        else if (w_run) w_state_nxt = ST_RUN;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_async) begin
    if (!reset_async) begin
      for (int i = 0; i < DEPTH; i++) r_prog[i] <= '0;
      r_len     <= '0;
      r_rd      <= '0;
      r_presc   <= '0;
      r_op      <= '0;
      r_data    <= '0;
      r_step    <= '0;
      r_cnt_en  <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_cnt_en  <= 1'b0;
      r_running <= (w_state_nxt == ST_RUN);
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            if (r_len != (SW+1)'(DEPTH)) begin
              r_prog[r_len[SW-1:0]] <= '{opcode: sw_opcode, data: sw_data};
              r_len <= r_len + (SW+1)'(1);
            end
          end else if (w_run && r_len != '0) begin
            r_rd    <= '0;
            r_presc <= '0;
          end
        end
        ST_RUN: begin
          if (w_tick) begin
            r_presc  <= '0;
            r_op     <= r_prog[r_rd].opcode;
            r_data   <= r_prog[r_rd].data;
            r_step   <= r_rd;
            r_cnt_en <= 1'b1;
            r_rd     <= (({1'b0, r_rd} + (SW+1)'(1)) == r_len) ? '0 : r_rd + SW'(1);
          end else if (enable) begin
            r_presc <= r_presc + PW'(1);
          end
        end
        ST_PAUSE: begin
          if (w_load) begin
            for (int i = 0; i < DEPTH; i++) r_prog[i] <= '0;
            r_len  <= '0;
            r_op   <= '0;
            r_data <= '0;
            r_step <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.opcode_out = r_op;
  assign bus.data_out   = r_data;
  assign bus.cnt_en     = r_cnt_en;
  assign bus.step       = r_step;
  assign bus.prog_len   = r_len;
  assign bus.running    = r_running;
endmodule
`default_nettype wire

// File: tb/tb_counter_sequencer.sv
// ---------------------------------------------------------------
// tb_counter_sequencer : directed + randomized bench with playback model
// rev 1.0
// ---------------------------------------------------------------
`default_nettype none
module tb_counter_sequencer;
  localparam int DEPTH = 4, OPW = 3, WIDTH = 4, TICK_DIV = 4, DEB = 2;

  typedef struct {
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic reset_async = 1'b0;
  logic load_btn = 1'b1, run_btn = 1'b1, enable = 1'b1;
  logic [OPW-1:0]   sw_opcode = '0;
  logic [WIDTH-1:0] sw_data = '0;

  int   n_tests = 0, n_fail = 0;
  ent_t prog_q[$];
  int   idx = 0, en_cnt = 0, n_pulses = 0;
  bit   fresh = 1'b0, prev_running = 1'b0;

  counter_sequencer_if #(.OPW(OPW), .WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  counter_sequencer #(
    .DEPTH(DEPTH), .OPW(OPW), .WIDTH(WIDTH), .TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk), .reset_async(reset_async), .load_btn(load_btn), .run_btn(run_btn),
    .enable(enable), .sw_opcode(sw_opcode), .sw_data(sw_data), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // which: 0 = load, 1 = run; held long enough for press and release to be accepted
  task automatic press(input int which);
    if (which == 0) load_btn = 1'b0; else run_btn = 1'b0;
    cyc(DEB + 4);
    load_btn = 1'b1;
    run_btn  = 1'b1;
    cyc(DEB + 4);
  endtask

  task automatic load_entry(input logic [OPW-1:0] op, input logic [WIDTH-1:0] d);
    ent_t e;
    sw_opcode = op;
    sw_data   = d;
    press(0);
    e.op = op;
    e.d  = d;
    if (prog_q.size() < DEPTH) prog_q.push_back(e);
    chk("prog_len_after_load", 32'(bus.prog_len), 32'(prog_q.size()));
  endtask

  task automatic wait_pulses(input int target, input bit rand_en);
    int t = 0;
    while (n_pulses < target && t < 2000) begin
      if (rand_en) enable = ($urandom_range(0, 3) != 0);
      cyc(1);
      t++;
    end
    enable = 1'b1;
    chk("pulse_timeout", 32'(n_pulses >= target), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_opcode"},   32'(bus.opcode_out), 32'd0);
    chk({tag, "_data"},     32'(bus.data_out),   32'd0);
    chk({tag, "_cnt_en"},   32'(bus.cnt_en),     32'd0);
    chk({tag, "_step"},     32'(bus.step),       32'd0);
    chk({tag, "_prog_len"}, 32'(bus.prog_len),   32'd0);
    chk({tag, "_running"},  32'(bus.running),    32'd0);
  endtask

  // Playback model: every TICK_DIV cycles spent running with enable high, the
  // next stored entry in program order must appear with a strobe.
  always @(negedge clk) begin
    if (reset_async) begin
      if (bus.running && !prev_running && fresh) begin
        en_cnt = 0;
        idx    = 0;
        fresh  = 1'b0;
      end
      if (bus.cnt_en) begin
        chk("cnt_en_gap", 32'(en_cnt), 32'(TICK_DIV));
        if (prog_q.size() == 0) begin
          chk("cnt_en_unexpected", 32'(bus.cnt_en), 32'd0);
        end else begin
          chk("step_opcode", 32'(bus.opcode_out), 32'(prog_q[idx].op));
          chk("step_data",   32'(bus.data_out),   32'(prog_q[idx].d));
          chk("step_index",  32'(bus.step),       32'(idx));
          idx = (idx + 1) % prog_q.size();
        end
        n_pulses++;
        en_cnt = 0;
      end
      if (bus.running && enable) en_cnt++;
      prev_running = bus.running;
    end else begin
      prev_running = 1'b0;
    end
  end

  initial begin
    int p0;
    cyc(3);
    chk_reset_outputs("in_reset");
    reset_async = 1'b1;
    cyc(2);
    chk_reset_outputs("after_reset");

    press(1);
    chk("run_empty_running", 32'(bus.running), 32'd0);
    chk("run_empty_len", 32'(bus.prog_len), 32'd0);

    load_entry(3'd1, 4'd5);
    load_entry(3'd2, 4'd7);
    load_entry(3'd3, 4'd9);

    // single-cycle glitch, shorter than the debounce window
    load_btn = 1'b0;
    cyc(1);
    load_btn = 1'b1;
    cyc(DEB + 6);
    chk("glitch_no_load", 32'(bus.prog_len), 32'd3);

    fresh = 1'b1;
    press(1);
    chk("run_running", 32'(bus.running), 32'd1);
    wait_pulses(2, 1'b0);

    enable = 1'b0;
    p0 = n_pulses;
    cyc(10);
    chk("no_pulse_enable_low", 32'(n_pulses), 32'(p0));
    enable = 1'b1;
    wait_pulses(5, 1'b0);
    wait_pulses(7, 1'b1);

    press(1);
    chk("pause_running", 32'(bus.running), 32'd0);
    p0 = n_pulses;
    cyc(20);
    chk("no_pulse_in_pause", 32'(n_pulses), 32'(p0));
    press(1);
    chk("resume_running", 32'(bus.running), 32'd1);
    wait_pulses(p0 + 3, 1'b1);

    press(1);
    chk("pause2_running", 32'(bus.running), 32'd0);
    press(0);
    prog_q.delete();
    chk_reset_outputs("clear_in_pause");

    for (int k = 0; k < 5; k++)
      load_entry(OPW'($urandom), WIDTH'($urandom));
    chk("len_saturates", 32'(bus.prog_len), 32'(DEPTH));

    fresh = 1'b1;
    p0 = n_pulses;
    press(1);
    wait_pulses(p0 + 9, 1'b1);

    @(posedge clk);
    #2;
    reset_async = 1'b0;
    #1;
    chk_reset_outputs("async_reset_mid_run");
    prog_q.delete();
    cyc(2);
    reset_async = 1'b1;
    cyc(3);
    chk("no_strobe_after_reset", 32'(bus.cnt_en), 32'd0);
    chk("idle_after_reset", 32'(bus.running), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/counter_sequencer.md
# counter_sequencer

Programmable step sequencer that drives the modulo-N counter datapath. Operators key up to DEPTH {opcode, data} steps from the board switches, then start playback. On each prescaled tick the block issues one step to the counter as a registered opcode/data pair with a one-cycle `cnt_en` strobe. It replaces the free-running derived 1 Hz clock with a single-clock-domain clock enable and sits between the switch/button inputs and the counter.

## Interface
- `DEPTH`, 4: program entries (power of two, ≥2)
- `OPW`, 3: opcode width
- `WIDTH`, 4: data width, matches the counter
- `TICK_DIV`, 50000000: clk cycles per playback tick (≥2)
- `DEB_CYCLES`, 10000: cycles a synchronized button level must be stable to be accepted (≥1)

- `clk`  in  1  board clock; single clock domain
- `reset_async`  in  1  asynchronous, active-low reset
- `load_btn`  in  1  active-low button; press = append/clear
- `run_btn`  in  1  active-low button; press = start/pause/resume
- `enable`  in  1  active-high; low stalls the tick prescaler
- `sw_opcode`  in  OPW  opcode to store on load
- `sw_data`  in  WIDTH  data to store on load
- `opcode_out`  out  OPW  step opcode to the counter
- `data_out`  out  WIDTH  step data to the counter
- `cnt_en`  out  1  one-cycle strobe: the counter consumes `opcode_out`/`data_out`
- `step`  out  log2(DEPTH)  index of the last issued step
- `prog_len`  out  log2(DEPTH)+1  number of stored steps, 0..DEPTH
- `running`  out  1  high in RUN

## Operation
- Button path: 2-flop synchronizer, then debounce. The accepted level updates only after DEB_CYCLES consecutive identical samples. A press event is a single-cycle pulse on an accepted 1→0 transition. Release generates no event.
- States: IDLE, RUN, PAUSE.
- IDLE:
  - load press with `prog_len`<DEPTH: prog[`prog_len`] ← {sw_opcode, sw_data}; `prog_len`++.
  - load press with `prog_len`==DEPTH: ignored.
  - run press with `prog_len`>0: go to RUN; rd_ptr←0; prescaler←0.
  - run press with `prog_len`==0: ignored.
- RUN:
  - Prescaler counts only while `enable`=1 and holds its value while `enable`=0.
  - Tick fires when prescaler==TICK_DIV-1; the prescaler then returns to 0.
  - On the tick edge: `opcode_out`/`data_out` ← prog[rd_ptr]; `step`←rd_ptr; `cnt_en`←1 for exactly one cycle; rd_ptr ← (rd_ptr+1==`prog_len`) ? 0 : rd_ptr+1.
  - run press: go to PAUSE.
  - load press: ignored.
- PAUSE:
  - Outputs hold, `cnt_en`=0, prescaler and rd_ptr frozen.
  - run press: resume RUN from the frozen prescaler/rd_ptr.
  - load press: clear program (`prog_len`←0, entries←0); `opcode_out`/`data_out`/`step`←0; go to IDLE.
- Simultaneous load and run press in the same cycle:
  - IDLE: load is processed, run dropped.
  - PAUSE: load (clear) wins.
  - RUN: run is processed.
- A tick and a run press in the same RUN cycle: the tick issues the step, and the state moves to PAUSE on the same edge.

## Timing
- Reset values: `opcode_out`=0, `data_out`=0, `cnt_en`=0, `step`=0, `prog_len`=0, `running`=0, state IDLE, prescaler=0, program=0, debounced levels=1 (released).
- Reset asserted mid-RUN clears everything immediately and asynchronously. No strobe is emitted on deassertion.
- Button latency: press event occurs 2 (sync) + DEB_CYCLES cycles after the pin falls, ±1.
- First step issue: `cnt_en` first rises TICK_DIV cycles after the cycle the run event is seen, assuming `enable` stays high.
- Tick period: TICK_DIV enabled cycles between consecutive `cnt_en` pulses.
- All outputs are registered, with no combinational path from inputs.
- `running` and state change on the edge after the press event.

## Structure
- Shared package `counter_seq_pkg` holds:
  - state enum {IDLE, RUN, PAUSE};
  - step entry struct {opcode[OPW], data[WIDTH]};
  - default OPW/WIDTH constants shared with the counter.
- Sub-module `button_conditioner` (sync + debounce + falling-edge pulse, parameter DEB_CYCLES), instantiated once per button.
- Program storage is a register array, not inferred RAM, because the block clears it in one cycle.

## Test plan
Bench uses TICK_DIV=4, DEB_CYCLES=2.
- Load, 3 presses with (1,5), (2,7), (3,9), then run → `prog_len`=3; `cnt_en` pulses every 4 cycles with data sequence 5,7,9,5,7 and `step` 0,1,2,0,1.
- Load 5 presses with DEPTH=4 → `prog_len` saturates at 4; the 5th entry is absent during playback.
- Run mid-playback, hold 20 cycles, run again → no `cnt_en` during PAUSE; the next issued step continues the sequence with prescaler phase preserved.
- `enable`=0 for 10 cycles in RUN → tick period stretches by exactly 10 cycles; no `cnt_en` while low.
- Run press in IDLE with empty program → stays IDLE, `running`=0. Load in PAUSE → `prog_len`=0, outputs 0, IDLE.
- Glitch pulse on `load_btn` shorter than DEB_CYCLES → no load. `reset_async` low during RUN → all outputs at reset values within the same cycle.
